// File: rtl/divider_16bit.sv
// divider_16bit -- multi-cycle unsigned restoring divider (DIVU/REMU).
// One subtract-and-shift step per clock; fixed WIDTH-cycle latency.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request a division (accepted in IDLE or DONE)
//   dividend, divisor operands, sampled only on the accepting edge
//   busy              high while the division is running
//   done              one-cycle pulse when results are loaded
//   quotient,remainder results, held until the next completion or reset
//   div_by_zero       latched divisor was zero (results follow RISC-V rules)
module divider_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
    logic [WIDTH:0]   r_q, r_d;        // partial remainder, one extra bit for borrow
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   p;
    logic [WIDTH:0]   diff;

    always_comb begin
        p     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff  = p - {1'b0, dvs_q};

        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    q_d     = dividend;
                    dvs_d   = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // MSB of diff is the borrow: set means P < divisor, restore P.
                q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH]};
                r_d   = diff[WIDTH] ? p : diff;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // A zero divisor never borrows, so Q ends all ones and R = dividend.
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                    dbz_d   = (dvs_q == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_16bit.sv
// tb_divider_16bit -- table vectors, directed corner sequences and random
// pairs; expected results are queued at issue time and checked on done.
module tb_divider_16bit;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    divider_16bit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard check, run at every falling edge.
    task automatic monitor();
        exp_t e;
        if (done) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: done=1 with no pending result (cycle %0d)", cyc);
            end else begin
                e = expq.pop_front();
                chk("latency", cyc, e.due);
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.dbz);
                chk("busy_in_done", busy, 0);
                if (e.b != 0) begin
                    chk("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    chk("rem_lt_div", 32'(remainder < e.b), 1);
                end
            end
        end else if (expq.size() != 0 && cyc > expq[0].due) begin
            checks++;
            failures++;
            $display("FAIL timeout: no done by cycle %0d (expected at %0d)", cyc, expq[0].due);
            void'(expq.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    // Drive a request on this falling edge; it is accepted at the next rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz; e.due = cyc + W + 1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        expq.push_back(e);
        tick();
        start    = 1'b0;
        dividend = $urandom_range(0, 65535);   // later changes must not matter
        divisor  = $urandom_range(0, 65535);
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic issue_m(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == 0) issue(a, b, '1, a, 1'b1);
        else        issue(a, b, a / b, a % b, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drained", expq.size(), 0);
        tick();
        chk("busy_idle", busy, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("saw_done", done, 1);
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{16'd100,  16'd7,    16'd14,   16'd2,   1'b0};
        tbl[1]  = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'd0,   1'b0};
        tbl[2]  = '{16'd3,    16'd10,   16'd0,    16'd3,   1'b0};
        tbl[3]  = '{16'd5,    16'd0,    16'hFFFF, 16'd5,   1'b1};
        tbl[4]  = '{16'd6,    16'd3,    16'd2,    16'd0,   1'b0};
        tbl[5]  = '{16'd200,  16'd13,   16'd15,   16'd5,   1'b0};
        tbl[6]  = '{16'd1000, 16'd3,    16'd333,  16'd1,   1'b0};
        tbl[7]  = '{16'd0,    16'd5,    16'd0,    16'd0,   1'b0};
        tbl[8]  = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0,   1'b0};
        tbl[9]  = '{16'd0,    16'd0,    16'hFFFF, 16'd0,   1'b1};
        tbl[10] = '{16'd1,    16'hFFFF, 16'd0,    16'd1,   1'b0};

        // Reset state
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz);
            wait_idle();
        end

        // Back-to-back: second request issued on the done cycle
        issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0);
        wait_done();
        issue(16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
        wait_idle();

        // Divide by zero, then a normal divide clears the flag
        issue(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        wait_idle();
        issue(16'd6, 16'd3, 16'd2, 16'd0, 1'b0);
        wait_idle();

        // start during RUN is ignored
        issue(16'd200, 16'd13, 16'd15, 16'd5, 1'b0);
        repeat (4) tick();
        dividend = 16'd9;
        divisor  = 16'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_idle();
        repeat (20) tick();
        chk("busy_after_ignore", busy, 0);

        // Asynchronous reset mid-operation
        issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
        repeat (7) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_q", quotient, 0);
        chk("arst_r", remainder, 0);
        chk("arst_dbz", div_by_zero, 0);
        expq.delete();
        tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("arst_no_restart", busy, 0);
        issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);
        wait_idle();

        // Random pairs with edge values mixed in
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a, b;
            a = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            case ($urandom_range(0, 7))
                0: b = 16'd0;
                1: b = 16'd1;
                2: a = 16'hFFFF;
                3: b = a;
                4: b = $urandom_range(1, 15);
                default: ;
            endcase
            issue_m(a, b);
            if (i % 2 == 1) wait_idle();
            else begin
                wait_done();
            end
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
